// File: rtl/traceback_pingpong_buffer_pkg.sv
// Shared definitions for the double-banked traceback direction memory.
// Holds the default geometry and the per-bank state encoding.
package traceback_pingpong_buffer_pkg;

  localparam int DIRECTION_WIDTH = 4;
  localparam int N               = 8;
  localparam int MEM_SIZE        = 256;
  localparam int ADDRESS_WIDTH   = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/traceback_pingpong_buffer_dir_ram_bank.sv
// Simple dual-port RAM bank: one write port, one registered read port with enable.
// The array is never reset; only the read register is.
module dir_ram_bank
  import traceback_pingpong_buffer_pkg::*;
#(
  parameter int WIDTH  = DIRECTION_WIDTH * N,
  parameter int DEPTH  = MEM_SIZE,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/traceback_pingpong_buffer.sv
// Ping-pong direction memory: the PE array fills one bank while traceback reads
// the other; banks swap through a commit (wr_last / full) and release (rd_done).
module traceback_pingpong_buffer
  import traceback_pingpong_buffer_pkg::*;
#(
  parameter int DIR_W  = DIRECTION_WIDTH,
  parameter int N      = traceback_pingpong_buffer_pkg::N,
  parameter int DEPTH  = MEM_SIZE,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  input  logic                 wr_last,
  input  logic [DIR_W*N-1:0]   wr_data,
  output logic                 wr_ready,
  output logic                 wr_ovf,
  output logic                 rd_avail,
  output logic [ADDR_W:0]      rd_len,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_valid,
  output logic [DIR_W*N-1:0]   rd_data,
  output logic                 rd_err,
  input  logic                 rd_done
);

  localparam int W = DIR_W * N;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  bank_state_e       state [2];
  logic              wbank, rbank;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   len [2];

  // Read-side hold registers: which bank drove the last read and whether it was forced to zero.
  logic              rd_sel_q, rd_zero_q;
  logic [W-1:0]      bank_q0, bank_q1;

  logic wr_accept, at_last_row, commit, rd_accept, rd_oob, rd_release;

  // Handshakes: a row moves when wr_valid & wr_ready; a read when rd_req & rd_avail.
  assign wr_ready    = (state[wbank] != FULL);
  assign rd_avail    = (state[rbank] == FULL);
  assign rd_len      = rd_avail ? len[rbank] : '0;
  assign wr_accept   = wr_valid & wr_ready;
  assign at_last_row = (wptr == LAST_ROW);
  assign commit      = wr_accept & (wr_last | at_last_row);
  assign rd_accept   = rd_req & rd_avail;
  assign rd_oob      = ({1'b0, rd_addr} >= len[rbank]);
  assign rd_release  = rd_done & rd_avail;
  assign rd_data     = rd_zero_q ? '0 : (rd_sel_q ? bank_q1 : bank_q0);

  dir_ram_bank #(.WIDTH(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_accept & ~wbank),
    .waddr (wptr),
    .wdata (wr_data),
    .re    (rd_accept & ~rbank),
    .raddr (rd_addr),
    .rdata (bank_q0)
  );

  dir_ram_bank #(.WIDTH(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_accept & wbank),
    .waddr (wptr),
    .wdata (wr_data),
    .re    (rd_accept & rbank),
    .raddr (rd_addr),
    .rdata (bank_q1)
  );

  // Commit and release always hit different banks (one is FULL, the other is not),
  // so both updates can land in the same cycle without conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state[0]  <= EMPTY;
      state[1]  <= EMPTY;
      len[0]    <= '0;
      len[1]    <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wptr      <= '0;
      wr_ovf    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      wr_ovf   <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;

      if (commit) begin
        state[wbank] <= FULL;
        len[wbank]   <= {1'b0, wptr} + 1'b1;
        wptr         <= '0;
        wbank        <= ~wbank;
        wr_ovf       <= at_last_row & ~wr_last;
      end else if (wr_accept) begin
        state[wbank] <= FILLING;
        wptr         <= wptr + 1'b1;
      end

      if (rd_accept) begin
        rd_valid  <= 1'b1;
        rd_err    <= rd_oob;
        rd_zero_q <= rd_oob;
        rd_sel_q  <= rbank;
      end

      if (rd_release) begin
        state[rbank] <= EMPTY;
        len[rbank]   <= '0;
        rbank        <= ~rbank;
      end
    end
  end

endmodule

// File: tb/tb_traceback_pingpong_buffer.sv
// Directed self-checking bench for the ping-pong traceback buffer.
module tb_traceback_pingpong_buffer;

  localparam int W  = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_last;
  logic [W-1:0]  wr_data;
  logic          wr_ready, wr_ovf, rd_avail;
  logic [AW:0]   rd_len;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_err, rd_done;

  int checks = 0;
  int errors = 0;

  traceback_pingpong_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_last  (wr_last),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .wr_ovf   (wr_ovf),
    .rd_avail (rd_avail),
    .rd_len   (rd_len),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .rd_done  (rd_done)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Driver tasks: inputs change #1 after the rising edge, outputs are read there too.
  task automatic write_row(input logic [W-1:0] d, input logic last);
    wr_valid = 1'b1; wr_data = d; wr_last = last;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic read_row(input logic [AW-1:0] a);
    rd_req = 1'b1; rd_addr = a;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic release_bank();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL reset_wr_ovf: got %b expected 0", wr_ovf); end
    checks++; if (rd_avail !== 1'b0) begin errors++; $display("FAIL reset_rd_avail: got %b expected 0", rd_avail); end
    checks++; if (rd_len !== 9'd0) begin errors++; $display("FAIL reset_rd_len: got %0d expected 0", rd_len); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err: got %b expected 0", rd_err); end
  endtask

  task automatic test_basic_fill_read();
    do_reset();
    for (int i = 1; i <= 5; i++) write_row(32'h11111111 * i, i == 5);
    checks++; if (rd_avail !== 1'b1) begin errors++; $display("FAIL basic_rd_avail: got %b expected 1", rd_avail); end
    checks++; if (rd_len !== 9'd5) begin errors++; $display("FAIL basic_rd_len: got %0d expected 5", rd_len); end
    checks++; if (dut.wbank !== 1'b1) begin errors++; $display("FAIL basic_wbank: got %b expected 1", dut.wbank); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL basic_wr_ready: got %b expected 1", wr_ready); end
    read_row(8'd2);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== 32'h33333333) begin errors++; $display("FAIL basic_rd_data: got %h expected 33333333", rd_data); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL basic_rd_err: got %b expected 0", rd_err); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 32'h33333333) begin errors++; $display("FAIL basic_data_hold: got %h expected 33333333", rd_data); end
  endtask

  task automatic test_out_of_range();
    read_row(8'd5);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL oob_rd_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL oob_rd_data: got %h expected 0", rd_data); end
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL oob_rd_err: got %b expected 1", rd_err); end
    read_row(8'd4);
    checks++; if (rd_data !== 32'h55555555) begin errors++; $display("FAIL inrange_rd_data: got %h expected 55555555", rd_data); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL inrange_rd_err: got %b expected 0", rd_err); end
    tick();
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL oob_err_pulse: got %b expected 0", rd_err); end
    rd_req = 1'b0; release_bank();
    checks++; if (rd_avail !== 1'b0) begin errors++; $display("FAIL release_rd_avail: got %b expected 0", rd_avail); end
    checks++; if (rd_len !== 9'd0) begin errors++; $display("FAIL release_rd_len: got %0d expected 0", rd_len); end
    read_row(8'd0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ignored_req_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 32'h55555555) begin errors++; $display("FAIL ignored_req_hold: got %h expected 55555555", rd_data); end
  endtask

  task automatic test_both_full();
    do_reset();
    for (int i = 0; i < 3; i++) write_row(32'hA0000000 + i, i == 2);
    for (int i = 0; i < 4; i++) write_row(32'hB0000000 + i, i == 3);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (rd_len !== 9'd3) begin errors++; $display("FAIL full_rd_len: got %0d expected 3", rd_len); end
    write_row(32'hDEADBEEF, 1'b1);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL blocked_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (rd_len !== 9'd3) begin errors++; $display("FAIL blocked_rd_len: got %0d expected 3", rd_len); end
    for (int i = 0; i < 3; i++) begin
      read_row(AW'(i));
      checks++; if (rd_data !== 32'hA0000000 + i) begin errors++; $display("FAIL blocked_bank0_row%0d: got %h expected %h", i, rd_data, 32'hA0000000 + i); end
    end
    release_bank();
    checks++; if (rd_len !== 9'd4) begin errors++; $display("FAIL swap_rd_len: got %0d expected 4", rd_len); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL swap_wr_ready: got %b expected 1", wr_ready); end
    read_row(8'd0);
    checks++; if (rd_data !== 32'hB0000000) begin errors++; $display("FAIL swap_bank1_row0: got %h expected b0000000", rd_data); end
    read_row(8'd3);
    checks++; if (rd_data !== 32'hB0000003) begin errors++; $display("FAIL swap_bank1_row3: got %h expected b0000003", rd_data); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      write_row(32'hABCDEF00 | i, 1'b0);
      checks++; if (wr_ovf !== (i == 255)) begin errors++; $display("FAIL ovf_row%0d: got %b expected %b", i, wr_ovf, i == 255); end
    end
    tick();
    checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width: got %b expected 0", wr_ovf); end
    checks++; if (rd_len !== 9'd256) begin errors++; $display("FAIL ovf_rd_len: got %0d expected 256", rd_len); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ovf_wr_ready: got %b expected 1", wr_ready); end
    write_row(32'hCAFEF00D, 1'b1);
    checks++; if (wr_ovf !== 1'b0) begin errors++; $display("FAIL ovf_last_commit: got %b expected 0", wr_ovf); end
    read_row(8'd255);
    checks++; if (rd_data !== 32'hABCDEFFF) begin errors++; $display("FAIL ovf_row255: got %h expected abcdefff", rd_data); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL ovf_row255_err: got %b expected 0", rd_err); end
    release_bank();
    checks++; if (rd_len !== 9'd1) begin errors++; $display("FAIL ovf_next_len: got %0d expected 1", rd_len); end
    read_row(8'd0);
    checks++; if (rd_data !== 32'hCAFEF00D) begin errors++; $display("FAIL ovf_next_row0: got %h expected cafef00d", rd_data); end
  endtask

  task automatic test_read_release_same_cycle();
    do_reset();
    for (int i = 0; i < 2; i++) write_row(32'h0000C000 + i, i == 1);
    for (int i = 0; i < 3; i++) write_row(32'h0000D000 + i, i == 2);
    rd_req = 1'b1; rd_addr = 8'd0; rd_done = 1'b1;
    tick();
    rd_req = 1'b0; rd_done = 1'b0;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL same_rd_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_data !== 32'h0000C000) begin errors++; $display("FAIL same_rd_data: got %h expected 0000c000", rd_data); end
    checks++; if (rd_avail !== 1'b1) begin errors++; $display("FAIL same_rd_avail: got %b expected 1", rd_avail); end
    checks++; if (rd_len !== 9'd3) begin errors++; $display("FAIL same_rd_len: got %0d expected 3", rd_len); end
    read_row(8'd0);
    checks++; if (rd_data !== 32'h0000D000) begin errors++; $display("FAIL same_next_data: got %h expected 0000d000", rd_data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    write_row(32'h00000E00, 1'b1);
    write_row(32'h00000F00, 1'b0);
    wr_valid = 1'b1; wr_data = 32'h00000F01; wr_last = 1'b1; rd_done = 1'b1;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0; rd_done = 1'b0;
    checks++; if (rd_len !== 9'd2) begin errors++; $display("FAIL b2b_rd_len: got %0d expected 2", rd_len); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready: got %b expected 1", wr_ready); end
    read_row(8'd1);
    checks++; if (rd_data !== 32'h00000F01) begin errors++; $display("FAIL b2b_row1: got %h expected 00000f01", rd_data); end
  endtask

  task automatic test_reset_midfill();
    do_reset();
    for (int i = 0; i < 2; i++) write_row(32'h0000AA00 + i, i == 1);
    for (int i = 0; i < 3; i++) write_row(32'h0000BB00 + i, 1'b0);
    read_row(8'd1);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", rd_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (rd_avail !== 1'b0) begin errors++; $display("FAIL midreset_rd_avail: got %b expected 0", rd_avail); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midreset_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midreset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL midreset_rd_data: got %h expected 0", rd_data); end
    tick();
    rst_n = 1'b1;
    tick();
    write_row(32'h00007777, 1'b1);
    checks++; if (rd_len !== 9'd1) begin errors++; $display("FAIL refill_rd_len: got %0d expected 1", rd_len); end
    checks++; if (dut.wbank !== 1'b1) begin errors++; $display("FAIL refill_wbank: got %b expected 1", dut.wbank); end
    read_row(8'd0);
    checks++; if (rd_data !== 32'h00007777) begin errors++; $display("FAIL refill_row0: got %h expected 00007777", rd_data); end
  endtask

  initial begin
    test_reset();
    test_basic_fill_read();
    test_out_of_range();
    test_both_full();
    test_overflow();
    test_read_release_same_cycle();
    test_back_to_back();
    test_reset_midfill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
